// File: rtl/move_command_transmitter.sv
// IR move-command transmitter: a 4-unit start mark and a 1-unit start space, then 12 mark-length coded bits, LSB first.
// Optional build macro MOVE_TX_REPEAT_EN: three copies per request, separated by a 20-unit gap.
module move_command_transmitter #(
   parameter int HALF_CARRIER = 338,
   parameter int UNIT_CYCLES  = 16200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        send,
   input  logic [11:0] command,
   output logic        busy,
   output logic        done,
   output logic        ir_out,
   output logic [2:0]  state
);

   // state       | meaning
   // IDLE        | waiting for send, ir_out low
   // START_MARK  | 4-unit carrier burst
   // START_SPACE | 1-unit silence
   // BIT_MARK    | carrier, 2 units for a one, 1 unit for a zero
   // BIT_SPACE   | 1-unit silence after each bit
   // GAP         | 20-unit silence between repeated copies
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      START_MARK  = 3'd1,
      START_SPACE = 3'd2,
      BIT_MARK    = 3'd3,
      BIT_SPACE   = 3'd4,
      GAP         = 3'd5
   } state_t;

   localparam int UW = $clog2(UNIT_CYCLES + 1);
   localparam int CW = $clog2(HALF_CARRIER + 1);

   state_t        st;
   logic [UW-1:0] unit_cnt;
   logic [CW-1:0] car_cnt;
   logic [4:0]    units_left;
   logic [3:0]    bit_idx;
   logic [11:0]   cmd_q;
`ifdef MOVE_TX_REPEAT_EN
   logic [1:0]    copy_cnt;
`endif

   logic       unit_tc;
   logic       seg_end;
   logic [3:0] bit_nxt;

   assign unit_tc = (unit_cnt == UW'(UNIT_CYCLES - 1));
   assign seg_end = unit_tc && (units_left == 5'd0);
   assign bit_nxt = bit_idx + 4'd1;
   assign state   = st;

   always_ff @(posedge clock) begin
      if (reset) begin
         st         <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ir_out     <= 1'b0;
         unit_cnt   <= '0;
         car_cnt    <= '0;
         units_left <= '0;
         bit_idx    <= '0;
         cmd_q      <= '0;
`ifdef MOVE_TX_REPEAT_EN
         copy_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (st == IDLE) begin
            if (send) begin
               cmd_q      <= command;
               bit_idx    <= '0;
               unit_cnt   <= '0;
               units_left <= 5'd3;
               car_cnt    <= '0;
               ir_out     <= 1'b1;
               busy       <= 1'b1;
               st         <= START_MARK;
`ifdef MOVE_TX_REPEAT_EN
               copy_cnt   <= '0;
`endif
            end
         end else begin
            unit_cnt <= unit_tc ? '0 : unit_cnt + 1'b1;
            if (unit_tc && units_left != 5'd0)
               units_left <= units_left - 5'd1;
            if (st == START_MARK || st == BIT_MARK) begin
               if (car_cnt == CW'(HALF_CARRIER - 1)) begin
                  car_cnt <= '0;
                  ir_out  <= ~ir_out;
               end else begin
                  car_cnt <= car_cnt + 1'b1;
               end
            end
            // segment boundaries override the per-cycle updates above
            if (seg_end) begin
               case (st)
                  START_MARK: begin
                     st         <= START_SPACE;
                     ir_out     <= 1'b0;
                     units_left <= 5'd0;
                  end
                  START_SPACE: begin
                     st         <= BIT_MARK;
                     ir_out     <= 1'b1;
                     car_cnt    <= '0;
                     units_left <= {4'd0, cmd_q[bit_idx]};
                  end
                  BIT_MARK: begin
                     st         <= BIT_SPACE;
                     ir_out     <= 1'b0;
                     units_left <= 5'd0;
                  end
                  BIT_SPACE: begin
                     if (bit_idx != 4'd11) begin
                        bit_idx    <= bit_nxt;
                        st         <= BIT_MARK;
                        ir_out     <= 1'b1;
                        car_cnt    <= '0;
                        units_left <= {4'd0, cmd_q[bit_nxt]};
                     end else begin
`ifdef MOVE_TX_REPEAT_EN
                        if (copy_cnt != 2'd2) begin
                           copy_cnt   <= copy_cnt + 2'd1;
                           st         <= GAP;
                           units_left <= 5'd19;
                        end else begin
                           st   <= IDLE;
                           busy <= 1'b0;
                           done <= 1'b1;
                        end
`else
                        st   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
`endif
                     end
                  end
                  GAP: begin
                     st         <= START_MARK;
                     bit_idx    <= '0;
                     units_left <= 5'd3;
                     ir_out     <= 1'b1;
                     car_cnt    <= '0;
                  end
                  default: begin
                     st     <= IDLE;
                     busy   <= 1'b0;
                     ir_out <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_move_command_transmitter.sv
// Bench for move_command_transmitter: random and directed requests, expected IR waveform built from the frame rules.
module tb_move_command_transmitter;

   localparam int HALF = 2;
   localparam int UNIT = 8;
`ifdef MOVE_TX_REPEAT_EN
   localparam int COPIES = 3;
`else
   localparam int COPIES = 1;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        send = 1'b0;
   logic [11:0] command = '0;
   logic        busy, done, ir_out;
   logic [2:0]  state;

   move_command_transmitter #(.HALF_CARRIER(HALF), .UNIT_CYCLES(UNIT)) dut (
      .clock(clock), .reset(reset), .send(send), .command(command),
      .busy(busy), .done(done), .ir_out(ir_out), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [11:0] cmd;
      int          start_edge;
   } frame_t;

   int     checks = 0;
   int     errors = 0;
   int     edge_cnt = 0;
   int     free_edge = 0;
   int     last_start = 0;
   int     accepts = 0;
   bit     mon_en = 0;
   bit     abort_flag = 0;
   frame_t sb[$];
   bit     wave[$];

   always @(posedge clock) edge_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add_seg(input int mark_u, input int space_u);
      for (int k = 0; k < mark_u * UNIT; k++) wave.push_back(((k / HALF) % 2) == 0);
      for (int k = 0; k < space_u * UNIT; k++) wave.push_back(1'b0);
   endfunction

   function automatic void build_wave(input logic [11:0] c);
      wave.delete();
      for (int cp = 0; cp < COPIES; cp++) begin
         if (cp > 0) add_seg(0, 20);
         add_seg(4, 1);
         for (int i = 0; i < 12; i++) add_seg(c[i] ? 2 : 1, 1);
      end
   endfunction

   function automatic int frame_len(input logic [11:0] c);
      int ones;
      ones = $countones(c);
      return COPIES * (5 + 2 * (12 - ones) + 3 * ones) * UNIT + (COPIES - 1) * 20 * UNIT;
   endfunction

   // monitor: pops an expected frame when busy rises and follows ir_out against it
   frame_t cur;
   bit     in_frame = 0;
   bit     ended;
   int     pos, first_bad, exp_len;
   always @(negedge clock) begin
      ended = 0;
      if (mon_en) begin
         if (busy === 1'b1 && !in_frame) begin
            chk("frame_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               cur = sb.pop_front();
               chk("start_edge", edge_cnt, cur.start_edge);
            end else begin
               cur.cmd = '0;
            end
            build_wave(cur.cmd);
            exp_len   = frame_len(cur.cmd);
            in_frame  = 1;
            pos       = 0;
            first_bad = -1;
         end
         if (in_frame) begin
            if (busy === 1'b1) begin
               if (first_bad < 0 && ir_out !== ((pos < wave.size()) ? wave[pos] : 1'b0))
                  first_bad = pos;
               if (done !== 1'b0) chk("done_while_busy", done, 0);
               pos++;
            end else begin
               in_frame = 0;
               ended    = 1;
               if (abort_flag) begin
                  chk("abort_no_done", done, 0);
                  chk("abort_ir", ir_out, 0);
                  abort_flag = 0;
               end else begin
                  chk("busy_len", pos, exp_len);
                  chk("ir_wave_first_bad_pos", first_bad, 32'hFFFF_FFFF);
                  chk("done_at_end", done, 1);
                  chk("ir_after_frame", ir_out, 0);
               end
            end
         end
         if (!in_frame && !ended) begin
            if (done !== 1'b0) chk("stray_done", done, 0);
            if (ir_out !== 1'b0) chk("ir_idle", ir_out, 0);
         end
`ifndef MOVE_TX_REPEAT_EN
         if (state === 3'd5) chk("gap_unreachable", state, 0);
`endif
      end
   end

   // one cycle of stimulus; the model decides acceptance from its own busy prediction
   task automatic step(input bit s, input logic [11:0] c);
      @(negedge clock);
      send    = s;
      command = c;
      if (s && edge_cnt + 1 >= free_edge) begin
         sb.push_back('{c, edge_cnt + 1});
         last_start = edge_cnt + 1;
         free_edge  = edge_cnt + 1 + frame_len(c) + 1;
         accepts++;
      end
   endtask

   task automatic wait_idle();
      while (edge_cnt < free_edge) step(0, 12'($urandom));
   endtask

   task automatic do_reset();
      @(negedge clock);
      if (mon_en && edge_cnt >= last_start && edge_cnt + 1 < free_edge) abort_flag = 1;
      reset = 1'b1;
      send  = 1'b0;
      @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ir", ir_out, 0);
      chk("rst_state", state, 0);
      free_edge = edge_cnt + 1;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int a0;
   initial begin
      repeat (3) @(negedge clock);
      do_reset();
      mon_en = 1;

      step(1, 12'h005); wait_idle();
      step(1, 12'hFFF); wait_idle();
      step(1, 12'h000); wait_idle();

      // a second request mid-frame must be ignored
      step(1, 12'h123);
      repeat (49) step(0, 12'($urandom));
      step(1, 12'h0AA);
      wait_idle();

      // reset 100 cycles into a frame
      step(1, 12'h5A5);
      repeat (99) step(0, 12'($urandom));
      do_reset();

      // send held high through done: back-to-back frames with one idle cycle
      a0 = accepts;
      step(1, 12'($urandom));
      while (accepts < a0 + 2) step(1, 12'($urandom));
      wait_idle();

      repeat (6) begin
         step(1, 12'($urandom));
         repeat ($urandom_range(0, 400)) step($urandom_range(0, 9) == 0, 12'($urandom));
      end
      step(0, 12'h000);
      wait_idle();

      repeat (5) step(0, 12'h000);
      chk("scoreboard_empty", sb.size(), 0);
      chk("no_open_frame", in_frame, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
